loop_page_buffer_sync: RTL and testbench
========================================

Name: loop_page_buffer_sync

Overview:
- Single-clock paged ring buffer: a RAM of 2^LOOP_WIDTH words split into FIFO_DEPTH pages of 2^WADDR_WIDTH words each.
- The writer fills the current page by explicit address and commits it with wr_wlast. The reader randomly addresses the oldest committed page and releases it with rd_rdy.
- Sits between a CPRI receive stream and downstream symbol processing, decoupling write order from read order per symbol page.

Parameters:
- WDATA_WIDTH, 64, write data width.
- WADDR_WIDTH, 12, in-page write address width.
- RDATA_WIDTH, 64, read data width; must equal WDATA_WIDTH.
- RADDR_WIDTH, 12, in-page read address width; must equal WADDR_WIDTH.
- READ_LATENCY, 3, cycles from rd_addr to rd_data; must be >=1.
- FIFO_DEPTH, 8, number of pages; must equal 2^(LOOP_WIDTH-WADDR_WIDTH).
- FIFO_WIDTH, 1, reserved; only value 1 is supported (elaboration error otherwise).
- LOOP_WIDTH, 15, total RAM address width.
- INFO_WIDTH, 1, per-page sideband info width.
- RAM_TYPE, 1, storage style: 1 = block RAM, 0 = distributed/MLAB. Behaviour is identical for both.

Ports:
- clk  in  1  clock.
- syn_rst  in  1  synchronous reset, active low.
- wr_wen  in  1  write strobe.
- wr_addr  in  WADDR_WIDTH  word address inside the current write page.
- wr_data  in  WDATA_WIDTH  write data.
- wr_wlast  in  1  commit current write page.
- wr_info  in  INFO_WIDTH  sideband info accumulated into the current page.
- free_size  out  LOOP_WIDTH-WADDR_WIDTH+1  number of uncommitted pages, FIFO_DEPTH minus committed count.
- rd_addr  in  RADDR_WIDTH  word address inside the head (oldest committed) page.
- rd_data  out  RDATA_WIDTH  read data, READ_LATENCY cycles after rd_addr.
- rd_vld  out  1  at least one committed page is present.
- rd_info  out  INFO_WIDTH  info of the head page.
- rd_rdy  in  1  release the head page.

Behaviour:

Reset:
- On clk edge with syn_rst=0: write page pointer, read page pointer, committed count, the current-page info accumulator and all page info entries go to 0.
- The rd_data pipeline is cleared to 0.
- Outputs after reset: free_size=FIFO_DEPTH, rd_vld=0, rd_info=0, rd_data=0.
- RAM contents are not cleared.
- Reset mid-operation discards all pages.

Write:
- Physical address = {wpage, wr_addr}.
- When wr_wen=1 and free_size!=0, mem[{wpage,wr_addr}] <= wr_data.
- When wr_wen=1 and free_size==0, the write is suppressed (drop).
- The info accumulator ORs in wr_info on every accepted write.

Commit:
- On wr_wlast=1 with free_size!=0: store the accumulator, including any wr_info from the same cycle, into info[wpage]; then wpage <= wpage+1 (mod FIFO_DEPTH), clear the accumulator, count++.
- A commit is independent of wr_wen.
- wr_wlast with free_size==0 is ignored.

Release:
- On rd_rdy=1 and rd_vld=1: rpage <= rpage+1 (mod FIFO_DEPTH), count--.
- rd_rdy with rd_vld=0 is ignored.
- Commit and release in the same cycle leave count unchanged; both pointers still move.

Status outputs:
- rd_vld = (count!=0) and free_size = FIFO_DEPTH-count, both decoded combinationally from registers.
- They reflect a commit or release on the cycle after it.
- rd_info = info[rpage].

Read:
- rd_addr is combined with the rpage value present in the same cycle, so a read issued in the cycle of a release still reads the old page.
- Data appears exactly READ_LATENCY cycles later and is pipelined every cycle (no enable).
- Reads are not gated by rd_vld; reading with no committed page returns RAM contents.
- Read and write to the same physical address in the same cycle return old data.

Pointers and arithmetic:
- Pointers are LOOP_WIDTH-WADDR_WIDTH bits and wrap naturally.
- count is LOOP_WIDTH-WADDR_WIDTH+1 bits, range 0..FIFO_DEPTH.

Test Plan:
- Reset: syn_rst=0 for 2 cycles, then 1 -> free_size=8, rd_vld=0, rd_info=0, rd_data=0.
- Single page: write addr 0..3169 with data=addr, wr_info=1 at addr 1, pulse wr_wlast -> next cycle rd_vld=1, free_size=7, rd_info=1. Read addr 5 -> rd_data=5 three cycles later.
- Release: rd_rdy=1 one cycle with one page committed -> rd_vld=0, free_size=8 next cycle. A read at addr 7 in the release cycle returns page 0 data.
- Fill/overflow: commit 8 pages with data = page*4096+addr -> free_size=0. A 9th page's writes and wr_wlast are dropped. Release one page, then read -> page-1 data intact, page order preserved.
- Simultaneous commit+release with count=3 -> count stays 3, free_size=5, rd_info becomes next page's info.
- Wrap: 20 commit/release cycles -> pointers wrap past 7, data and info of each page are read back in order.
- Reset mid-operation: reset asserted with 4 committed pages -> rd_vld=0, free_size=8 after reset.

Source files
------------

// File: rtl/loop_page_buffer_sync.sv
// Paged ring buffer: the writer fills and commits whole pages, the reader randomly
// addresses the oldest committed page and releases it when done.
module loop_page_buffer_sync #(
    parameter int WDATA_WIDTH  = 64,
    parameter int WADDR_WIDTH  = 12,
    parameter int RDATA_WIDTH  = 64,
    parameter int RADDR_WIDTH  = 12,
    parameter int READ_LATENCY = 3,
    parameter int FIFO_DEPTH   = 8,
    parameter int FIFO_WIDTH   = 1,
    parameter int LOOP_WIDTH   = 15,
    parameter int INFO_WIDTH   = 1,
    parameter int RAM_TYPE     = 1
) (
    input  logic                             clk,
    input  logic                             syn_rst,
    input  logic                             wr_wen,
    input  logic [WADDR_WIDTH-1:0]           wr_addr,
    input  logic [WDATA_WIDTH-1:0]           wr_data,
    input  logic                             wr_wlast,
    input  logic [INFO_WIDTH-1:0]            wr_info,
    output logic [LOOP_WIDTH-WADDR_WIDTH:0]  free_size,
    input  logic [RADDR_WIDTH-1:0]           rd_addr,
    output logic [RDATA_WIDTH-1:0]           rd_data,
    output logic                             rd_vld,
    output logic [INFO_WIDTH-1:0]            rd_info,
    input  logic                             rd_rdy
);

    localparam int PW = LOOP_WIDTH - WADDR_WIDTH;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);

    if (FIFO_WIDTH != 1) begin : g_bad_fifo_width
        $error("loop_page_buffer_sync: FIFO_WIDTH must be 1");
    end
    if (RAM_TYPE != 0 && RAM_TYPE != 1) begin : g_bad_ram_type
        $error("loop_page_buffer_sync: RAM_TYPE must be 0 or 1");
    end
    if (RDATA_WIDTH != WDATA_WIDTH || RADDR_WIDTH != WADDR_WIDTH) begin : g_bad_widths
        $error("loop_page_buffer_sync: read and write widths must match");
    end
    if (READ_LATENCY < 1) begin : g_bad_latency
        $error("loop_page_buffer_sync: READ_LATENCY must be at least 1");
    end
    if (FIFO_DEPTH != (1 << PW)) begin : g_bad_depth
        $error("loop_page_buffer_sync: FIFO_DEPTH must equal 2**(LOOP_WIDTH-WADDR_WIDTH)");
    end

    logic [WDATA_WIDTH-1:0] mem [0:(2**LOOP_WIDTH)-1];
    logic [INFO_WIDTH-1:0]  info_mem [0:FIFO_DEPTH-1];
    logic [RDATA_WIDTH-1:0] rd_pipe [0:READ_LATENCY-1];

    logic [PW-1:0]          wpage;
    logic [PW-1:0]          rpage;
    logic [CW-1:0]          count;
    logic [INFO_WIDTH-1:0]  info_acc;
    logic [INFO_WIDTH-1:0]  info_next;
    logic                   full;
    logic                   wr_ok;
    logic                   commit;
    logic                   rel_pg;

    assign full      = (count == DEPTH);
    assign wr_ok     = wr_wen & ~full;
    assign commit    = wr_wlast & ~full;
    assign rel_pg    = rd_rdy & rd_vld;
    // info from a write accepted in the commit cycle belongs to the page being closed
    assign info_next = info_acc | (wr_ok ? wr_info : '0);

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[{wpage, wr_addr}] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!syn_rst) begin
            wpage    <= '0;
            rpage    <= '0;
            count    <= '0;
            info_acc <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                info_mem[i] <= '0;
            end
        end else begin
            if (commit) begin
                info_mem[wpage] <= info_next;
                wpage           <= wpage + 1'b1;
                info_acc        <= '0;
            end else begin
                info_acc <= info_next;
            end
            if (rel_pg) begin
                rpage <= rpage + 1'b1;
            end
            case ({commit, rel_pg})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // read uses the pre-release rpage, so a read in the release cycle hits the old page
    always_ff @(posedge clk) begin
        if (!syn_rst) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                rd_pipe[i] <= '0;
            end
        end else begin
            rd_pipe[0] <= mem[{rpage, rd_addr}];
            for (int i = 1; i < READ_LATENCY; i++) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end
        end
    end

    assign free_size = DEPTH - count;
    assign rd_vld    = (count != '0);
    assign rd_info   = info_mem[rpage];
    assign rd_data   = rd_pipe[READ_LATENCY-1];

endmodule

// File: tb/tb_loop_page_buffer_sync.sv
// Bench for loop_page_buffer_sync: table vectors, directed page sequences and a
// randomized run against a page-level reference model.
module tb_loop_page_buffer_sync;

    logic        clk = 1'b0;
    logic        syn_rst;
    logic        wr_wen;
    logic [11:0] wr_addr;
    logic [63:0] wr_data;
    logic        wr_wlast;
    logic [0:0]  wr_info;
    logic [3:0]  free_size;
    logic [11:0] rd_addr;
    logic [63:0] rd_data;
    logic        rd_vld;
    logic [0:0]  rd_info;
    logic        rd_rdy;

    int total = 0;
    int bad   = 0;

    loop_page_buffer_sync dut (
        .clk       (clk),
        .syn_rst   (syn_rst),
        .wr_wen    (wr_wen),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_wlast  (wr_wlast),
        .wr_info   (wr_info),
        .free_size (free_size),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_vld    (rd_vld),
        .rd_info   (rd_info),
        .rd_rdy    (rd_rdy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wen;
        logic [11:0] addr;
        logic [63:0] data;
        logic        wlast;
        logic        info;
        logic        rdy;
        int          exp_free;
        logic        exp_vld;
        logic        exp_info;
    } vec_t;

    typedef struct {
        logic [63:0] base;
        logic        inf;
    } page_t;

    vec_t  tv [9];
    page_t sb [$];
    int    wp_tb;

    localparam int NRAND = 600;
    logic [63:0] mdl [int];
    logic        hk [NRAND];
    logic [63:0] hv [NRAND];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk_status(input string tag, input int f, input logic v, input logic i);
        chk({tag, "_free"}, 64'(free_size), 64'(f));
        chk({tag, "_vld"},  64'(rd_vld),    64'(v));
        chk({tag, "_info"}, 64'(rd_info),   64'(i));
    endtask

    task automatic idle();
        wr_wen   = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        wr_wlast = 1'b0;
        wr_info  = '0;
        rd_rdy   = 1'b0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [63:0] d, input logic inf);
        wr_wen  = 1'b1;
        wr_addr = a;
        wr_data = d;
        wr_info = inf;
        step();
        wr_wen  = 1'b0;
        wr_info = '0;
    endtask

    task automatic commit_pulse();
        wr_wlast = 1'b1;
        step();
        wr_wlast = 1'b0;
    endtask

    task automatic release_pulse();
        rd_rdy = 1'b1;
        step();
        rd_rdy = 1'b0;
    endtask

    task automatic read_chk(input string nm, input logic [11:0] a, input logic [63:0] exp);
        rd_addr = a;
        step();
        step();
        step();
        chk(nm, rd_data, exp);
    endtask

    // writes addresses 0..n-1 with data base+addr; the page info rides on address 0
    task automatic write_page(input logic [63:0] base, input logic inf, input int n, input bit do_commit);
        page_t p;
        for (int a = 0; a < n; a++) begin
            wr(12'(a), base + 64'(a), (a == 0) ? inf : 1'b0);
        end
        p.base = base;
        p.inf  = inf;
        sb.push_back(p);
        wp_tb = (wp_tb + 1) % 8;
        if (do_commit) commit_pulse();
    endtask

    task automatic do_reset(input int cycles);
        syn_rst = 1'b0;
        for (int i = 0; i < cycles; i++) step();
    endtask

    initial begin
        // wen addr data wlast info rdy | free vld info
        tv[0] = '{1'b1, 12'd0, 64'h11, 1'b0, 1'b0, 1'b0, 8, 1'b0, 1'b0};
        tv[1] = '{1'b1, 12'd1, 64'h22, 1'b1, 1'b1, 1'b0, 7, 1'b1, 1'b1};
        tv[2] = '{1'b0, 12'd0, 64'h0,  1'b1, 1'b0, 1'b0, 6, 1'b1, 1'b1};
        tv[3] = '{1'b0, 12'd0, 64'h0,  1'b0, 1'b0, 1'b1, 7, 1'b1, 1'b0};
        tv[4] = '{1'b0, 12'd0, 64'h0,  1'b1, 1'b0, 1'b1, 7, 1'b1, 1'b0};
        tv[5] = '{1'b0, 12'd0, 64'h0,  1'b0, 1'b0, 1'b1, 8, 1'b0, 1'b0};
        tv[6] = '{1'b0, 12'd0, 64'h0,  1'b0, 1'b0, 1'b1, 8, 1'b0, 1'b0};
        tv[7] = '{1'b1, 12'd2, 64'h33, 1'b0, 1'b1, 1'b0, 8, 1'b0, 1'b0};
        tv[8] = '{1'b0, 12'd0, 64'h0,  1'b1, 1'b0, 1'b0, 7, 1'b1, 1'b1};

        idle();
        rd_addr = '0;
        do_reset(2);
        syn_rst = 1'b1;

        for (int i = 0; i < 9; i++) begin
            wr_wen   = tv[i].wen;
            wr_addr  = tv[i].addr;
            wr_data  = tv[i].data;
            wr_wlast = tv[i].wlast;
            wr_info  = tv[i].info;
            rd_rdy   = tv[i].rdy;
            step();
            chk_status($sformatf("vec%0d", i), tv[i].exp_free, tv[i].exp_vld, tv[i].exp_info);
        end
        idle();

        // reset state, checked while reset is still held so rd_data is the cleared pipe
        do_reset(2);
        chk_status("reset", 8, 1'b0, 1'b0);
        chk("reset_rd_data", rd_data, 64'h0);
        syn_rst = 1'b1;

        // single page: data = address, info set on address 1 only
        for (int a = 0; a < 3170; a++) begin
            wr(12'(a), 64'(a), (a == 1) ? 1'b1 : 1'b0);
        end
        commit_pulse();
        chk_status("single", 7, 1'b1, 1'b1);
        read_chk("single_rd5", 12'd5, 64'd5);

        // release with a read in the same cycle still sees page 0
        rd_addr = 12'd7;
        release_pulse();
        chk_status("release", 8, 1'b0, 1'b0);
        step();
        step();
        chk("release_rd7", rd_data, 64'd7);

        // fill all eight pages, data = physical page * 4096 + addr
        wp_tb = 1;
        sb.delete();
        for (int p = 0; p < 8; p++) begin
            write_page(64'(wp_tb) * 64'd4096, 1'(p % 2), 16, 1'b1);
        end
        chk_status("full", 0, 1'b1, sb[0].inf);
        wr(12'd0, 64'hDEAD_BEEF, 1'b1);
        commit_pulse();
        chk_status("overflow", 0, 1'b1, sb[0].inf);
        read_chk("overflow_keep", 12'd0, sb[0].base);
        release_pulse();
        void'(sb.pop_front());
        chk_status("free1", 1, 1'b1, sb[0].inf);
        read_chk("after_rel_rd3", 12'd3, sb[0].base + 64'd3);
        for (int k = 0; k < 4; k++) begin
            read_chk($sformatf("order%0d", k), 12'd5, sb[0].base + 64'd5);
            release_pulse();
            void'(sb.pop_front());
        end
        chk_status("count3", 5, 1'b1, sb[0].inf);

        // commit and release in the same cycle with three pages held
        for (int a = 0; a < 4; a++) wr(12'(a), 64'h5000 + 64'(a), (a == 0) ? 1'b1 : 1'b0);
        begin
            page_t p;
            p.base = 64'h5000;
            p.inf  = 1'b1;
            sb.push_back(p);
            wp_tb = (wp_tb + 1) % 8;
        end
        wr_wlast = 1'b1;
        rd_rdy   = 1'b1;
        step();
        idle();
        void'(sb.pop_front());
        chk_status("simul", 5, 1'b1, sb[0].inf);

        // wrap pointers with a steady three-page backlog
        for (int it = 0; it < 20; it++) begin
            write_page(64'hA000_0000 + 64'(it) * 64'd64, 1'(it % 2), 4, 1'b1);
            chk($sformatf("wrap%0d_info", it), 64'(rd_info), 64'(sb[0].inf));
            read_chk($sformatf("wrap%0d_rd2", it), 12'd2, sb[0].base + 64'd2);
            release_pulse();
            void'(sb.pop_front());
        end
        chk_status("wrap_end", 5, 1'b1, sb[0].inf);

        // reset with four committed pages discards them
        write_page(64'hB000, 1'b1, 2, 1'b1);
        chk_status("pre_reset", 4, 1'b1, sb[0].inf);
        do_reset(1);
        syn_rst = 1'b1;
        chk_status("mid_reset", 8, 1'b0, 1'b0);
        sb.delete();

        // randomized run against a page-level model; addresses 4000..4007 are fresh
        begin
            int       cnt_m = 0;
            int       wp_m = 0;
            int       rp_m = 0;
            logic     acc_m = 1'b0;
            logic     info_m [8];
            logic     wen, wl, rdy, inf;
            logic [11:0] wa, ra;
            logic [63:0] wd;
            bit       full_m, acc_wr, com, rel;
            int       key;
            for (int i = 0; i < 8; i++) info_m[i] = 1'b0;
            for (int n = 0; n < NRAND; n++) begin
                wen = ($urandom_range(0, 3) != 0);
                wa  = 12'(4000 + $urandom_range(0, 7));
                ra  = 12'(4000 + $urandom_range(0, 7));
                wd  = {$urandom, $urandom};
                inf = wen ? 1'($urandom_range(0, 3) == 0) : 1'b0;
                if (n < NRAND / 2) begin
                    wl  = ($urandom_range(0, 2) == 0);
                    rdy = ($urandom_range(0, 7) == 0);
                end else begin
                    wl  = ($urandom_range(0, 7) == 0);
                    rdy = ($urandom_range(0, 2) == 0);
                end
                wr_wen = wen; wr_addr = wa; wr_data = wd; wr_wlast = wl;
                wr_info = inf; rd_rdy = rdy; rd_addr = ra;

                key   = rp_m * 4096 + int'(ra);
                hk[n] = mdl.exists(key);
                hv[n] = hk[n] ? mdl[key] : 64'h0;

                full_m = (cnt_m == 8);
                acc_wr = wen && !full_m;
                com    = wl && !full_m;
                rel    = rdy && (cnt_m != 0);
                if (acc_wr) mdl[wp_m * 4096 + int'(wa)] = wd;
                if (com) begin
                    info_m[wp_m] = acc_m | (acc_wr ? inf : 1'b0);
                    acc_m = 1'b0;
                    wp_m  = (wp_m + 1) % 8;
                end else if (acc_wr) begin
                    acc_m = acc_m | inf;
                end
                if (rel) rp_m = (rp_m + 1) % 8;
                cnt_m = cnt_m + (com ? 1 : 0) - (rel ? 1 : 0);

                step();
                chk_status($sformatf("rnd%0d", n), 8 - cnt_m, (cnt_m != 0), info_m[rp_m]);
                if (n >= 2 && hk[n-2]) begin
                    chk($sformatf("rnd%0d_data", n), rd_data, hv[n-2]);
                end
            end
            idle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
